// File: rtl/mmio_timer_intc_pkg.sv
// Shared register map, CTRL field layout and helpers for the MMIO timer/interrupt block.
package mmio_timer_intc_pkg;

    // Byte offsets within the 32-byte register window
    localparam logic [4:0] OFF_COUNT   = 5'h00;
    localparam logic [4:0] OFF_COMPARE = 5'h04;
    localparam logic [4:0] OFF_CTRL    = 5'h08;
    localparam logic [4:0] OFF_PENDING = 5'h0C;
    localparam logic [4:0] OFF_MASK    = 5'h10;

    // CTRL field positions
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_PS_LSB      = 8;
    localparam int CTRL_PS_MSB      = 15;

    // Only EN, AUTO_RELOAD and PRESCALE are storage; everything else reads 0
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF03;

    localparam int          NUM_EXT_IRQ   = 5;
    localparam int          IRQ_TIMER_BIT = 5;
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace the byte lanes of old_val selected by sel with the matching lanes of new_val
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_intc_irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, followed by a
// rising-edge detector that emits a single-cycle pulse.
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchroniser and remember the last synchronised level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is combinational so the pending bit lands SYNC_STAGES+1 cycles after the input rises
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mmio_timer_intc.sv
// Memory-mapped prescaled 32-bit timer with compare match, plus a small
// interrupt controller (pending/mask) for the timer and five external lines.
module mmio_timer_intc
    import mmio_timer_intc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_DMEM_addr,
    input  logic [31:0] i_DMEM_wdata,
    input  logic        i_DMEM_we,
    input  logic [3:0]  i_DMEM_sel,
    output logic [31:0] o_rdata,
    output logic        o_hit,
    input  logic [4:0]  i_ext_irq,
    output logic [5:0]  o_interuption
);

    logic        win_hit;
    logic [4:0]  reg_off;
    logic        wr_en;
    logic        wr_count, wr_compare, wr_ctrl, wr_pending, wr_mask;

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] ctrl_q;
    logic [5:0]  pend_q;
    logic [5:0]  mask_q;
    logic [7:0]  ps_q;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic [7:0]  prescale;
    logic        tick;
    logic        timer_match;
    logic [4:0]  ext_pulse;
    logic [5:0]  hw_set;
    logic [5:0]  w1c;
    logic [31:0] rd_mux;
    logic        unused_addr_lsbs;

    // Address decode: the low two address bits never select anything
    assign win_hit          = (i_DMEM_addr[31:5] == BASE_ADDR[31:5]);
    assign reg_off          = {i_DMEM_addr[4:2], 2'b00};
    assign wr_en            = win_hit & i_DMEM_we;
    assign wr_count         = wr_en && (reg_off == OFF_COUNT);
    assign wr_compare       = wr_en && (reg_off == OFF_COMPARE);
    assign wr_ctrl          = wr_en && (reg_off == OFF_CTRL);
    assign wr_pending       = wr_en && (reg_off == OFF_PENDING);
    assign wr_mask          = wr_en && (reg_off == OFF_MASK);
    assign unused_addr_lsbs = ^i_DMEM_addr[1:0];

    assign ctrl_en   = ctrl_q[CTRL_EN];
    assign ctrl_auto = ctrl_q[CTRL_AUTO_RELOAD];
    assign prescale  = ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB];

    // A tick uses the current CTRL, so a write clearing EN still lets this cycle's tick complete
    assign tick        = ctrl_en && (ps_q == prescale);
    // A COUNT write overrides the tick, so no match is evaluated in that cycle
    assign timer_match = tick && !wr_count && (count_q == compare_q);

    assign hw_set = {timer_match, ext_pulse};
    // PENDING bits all live in byte lane 0
    assign w1c    = wr_pending ? (i_DMEM_wdata[5:0] & {6{i_DMEM_sel[0]}}) : 6'b0;

    for (genvar g = 0; g < NUM_EXT_IRQ; g++) begin : g_ext_sync
        irq_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_irq_edge_sync (
            .clk      (clk),
            .resetn   (resetn),
            .async_in (i_ext_irq[g]),
            .pulse    (ext_pulse[g])
        );
    end

    // Prescaler: free-runs while enabled and wraps to 0 on every tick
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ps_q <= '0;
        end else if (tick) begin
            ps_q <= '0;
        end else if (ctrl_en) begin
            ps_q <= ps_q + 8'd1;
        end
    end

    // Main counter: software write has priority, otherwise advance or reload on a tick
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= byte_merge(count_q, i_DMEM_wdata, i_DMEM_sel);
        end else if (tick) begin
            count_q <= (timer_match && ctrl_auto) ? 32'd0 : count_q + 32'd1;
        end
    end

    // Software-owned configuration registers: COMPARE, CTRL, MASK
    always_ff @(posedge clk) begin
        if (!resetn) begin
            compare_q <= COMPARE_RESET;
            ctrl_q    <= '0;
            mask_q    <= '0;
        end else begin
            if (wr_compare) compare_q <= byte_merge(compare_q, i_DMEM_wdata, i_DMEM_sel);
            if (wr_ctrl)    ctrl_q    <= byte_merge(ctrl_q, i_DMEM_wdata, i_DMEM_sel) & CTRL_WMASK;
            if (wr_mask)    mask_q    <= byte_merge({26'b0, mask_q}, i_DMEM_wdata, i_DMEM_sel) & 32'h3F;
        end
    end

    // Pending: W1C first, then hardware sets on top so a coinciding event is never lost
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~w1c) | hw_set;
        end
    end

    // Register read selection for the current address
    always_comb begin
        rd_mux = '0;
        case (reg_off)
            OFF_COUNT:   rd_mux = count_q;
            OFF_COMPARE: rd_mux = compare_q;
            OFF_CTRL:    rd_mux = ctrl_q;
            OFF_PENDING: rd_mux = {26'b0, pend_q};
            OFF_MASK:    rd_mux = {26'b0, mask_q};
            default:     rd_mux = '0;
        endcase
    end

    // One-cycle read pipeline: data and hit flag follow the address by one clock
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_rdata <= '0;
            o_hit   <= 1'b0;
        end else begin
            o_hit   <= win_hit;
            o_rdata <= win_hit ? rd_mux : 32'd0;
        end
    end

    assign o_interuption = pend_q & mask_q;

endmodule

// File: tb/tb_mmio_timer_intc.sv
// Directed and randomized checks of mmio_timer_intc against a behavioural model.
module tb_mmio_timer_intc;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_we = 1'b0;
    logic [3:0]  dmem_sel = '0;
    logic [31:0] rdata;
    logic        hit;
    logic [4:0]  ext_irq = '0;
    logic [5:0]  irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_count, m_compare, m_ctrl, m_rdata;
    logic [5:0]  m_pend, m_mask;
    logic        m_hit;
    int          m_ps;
    logic [4:0]  sh0, sh1, sh2;
    logic [4:0]  ext_cur = '0;

    mmio_timer_intc #(
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_DMEM_addr   (dmem_addr),
        .i_DMEM_wdata  (dmem_wdata),
        .i_DMEM_we     (dmem_we),
        .i_DMEM_sel    (dmem_sel),
        .o_rdata       (rdata),
        .o_hit         (hit),
        .i_ext_irq     (ext_irq),
        .o_interuption (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_ctrl = 0; m_pend = 0; m_mask = 0;
        m_ps = 0; sh0 = 0; sh1 = 0; sh2 = 0; m_rdata = 0; m_hit = 0;
    endtask

    // One clock: drive inputs, advance the model by the register rules, check outputs after the edge
    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [3:0] sel);
        logic        h, wr, en, tick, cw, tset;
        logic [2:0]  idx;
        logic [31:0] rv, n_count, n_compare, n_ctrl;
        logic [5:0]  n_pend, n_mask, clr;
        logic [4:0]  ev;
        int          n_ps;
        dmem_addr = a; dmem_wdata = wd; dmem_we = we; dmem_sel = sel; ext_irq = ext_cur;
        h   = (a[31:5] == BASE[31:5]);
        idx = a[4:2];
        wr  = h && we;
        case (idx)
            3'd0: rv = m_count;
            3'd1: rv = m_compare;
            3'd2: rv = m_ctrl;
            3'd3: rv = {26'b0, m_pend};
            3'd4: rv = {26'b0, m_mask};
            default: rv = 0;
        endcase
        en   = m_ctrl[0];
        tick = en && (m_ps == int'(m_ctrl[15:8]));
        cw   = wr && (idx == 3'd0);
        tset = tick && !cw && (m_count == m_compare);
        ev   = sh1 & ~sh2;
        n_count = m_count;
        if (cw) n_count = lanes(m_count, wd, sel);
        else if (tick) n_count = (tset && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        n_ps = tick ? 0 : (en ? (m_ps + 1) % 256 : m_ps);
        n_compare = (wr && idx == 3'd1) ? lanes(m_compare, wd, sel) : m_compare;
        n_ctrl    = (wr && idx == 3'd2) ? (lanes(m_ctrl, wd, sel) & 32'h0000_FF03) : m_ctrl;
        n_mask    = (wr && idx == 3'd4) ? lanes({26'b0, m_mask}, wd, sel) & 6'h3F : m_mask;
        clr       = (wr && idx == 3'd3 && sel[0]) ? wd[5:0] : 6'b0;
        n_pend    = (m_pend & ~clr) | {tset, ev};
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            m_rdata = h ? rv : 32'd0; m_hit = h;
            m_count = n_count; m_ps = n_ps; m_compare = n_compare; m_ctrl = n_ctrl;
            m_mask = n_mask; m_pend = n_pend;
            sh2 = sh1; sh1 = sh0; sh0 = ext_cur;
        end
        #1;
        chk("rdata", rdata, m_rdata);
        chk("hit", {31'b0, hit}, {31'b0, m_hit});
        chk("irq", {26'b0, irq}, {26'b0, m_pend & m_mask});
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] wd, input logic [3:0] sel);
        cycle(BASE + 32'(idx * 4), wd, 1'b1, sel);
    endtask

    task automatic rd_reg(input int idx);
        cycle(BASE + 32'(idx * 4), 32'd0, 1'b0, 4'h0);
    endtask

    task automatic idle();
        cycle(32'h0, 32'd0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(); idle();
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_reset [5];
        logic [31:0] ra, rw;
        int          ridx;
        exp_reset = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        model_reset();
        do_reset();

        // Reset values of every register
        for (int i = 0; i < 5; i++) begin
            rd_reg(i);
            chk($sformatf("reset_reg%0d", i), rdata, exp_reset[i]);
            chk("reset_hit", {31'b0, hit}, 32'd1);
        end
        chk("reset_irq", {26'b0, irq}, 32'd0);

        // Auto-reload with COMPARE=5, PRESCALE=0
        wr_reg(1, 32'd5, 4'hF);
        wr_reg(4, 32'h20, 4'hF);
        wr_reg(2, 32'h3, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            rd_reg(0);
            chk($sformatf("reload_count_k%0d", k), rdata, 32'((k - 1) % 6));
            if (k == 5) chk("match_early", {31'b0, irq[5]}, 32'd0);
            if (k == 6) chk("match_at7", {31'b0, irq[5]}, 32'd1);
        end
        wr_reg(2, 32'h0, 4'hF);
        wr_reg(3, 32'h3F, 4'h1);
        wr_reg(4, 32'h0, 4'hF);

        // PRESCALE=3: one increment per 4 cycles, then freeze
        wr_reg(0, 32'h0, 4'hF);
        wr_reg(2, 32'h301, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            rd_reg(0);
            chk($sformatf("ps3_count_k%0d", k), rdata, 32'((k - 1) / 4));
        end
        wr_reg(2, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            rd_reg(0);
            chk("frozen_count", rdata, 32'd3);
        end

        // External line 2: latency, W1C while the level is still high
        wr_reg(4, 32'h04, 4'hF);
        ext_cur = 5'b00100;
        idle(); idle();
        chk("ext2_early", {26'b0, irq}, 32'd0);
        idle();
        chk("ext2_set", {26'b0, irq}, 32'h4);
        wr_reg(3, 32'h4, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("ext2_stays_clear", {26'b0, irq}, 32'd0);
        end
        ext_cur = 5'b0;
        repeat (3) idle();

        // Edge on line 0 coinciding with W1C of bit 0: set wins
        wr_reg(4, 32'h01, 4'hF);
        ext_cur = 5'b00001;
        repeat (3) idle();
        ext_cur = 5'b0;
        repeat (3) idle();
        ext_cur = 5'b00001;
        idle(); idle();
        wr_reg(3, 32'h1, 4'b0001);
        chk("set_beats_w1c", {31'b0, irq[0]}, 32'd1);
        wr_reg(3, 32'h1, 4'b0001);
        chk("w1c_later", {31'b0, irq[0]}, 32'd0);
        ext_cur = 5'b0;

        // Byte-lane store and out-of-window access
        do_reset();
        wr_reg(1, 32'h0000_AB00, 4'b0010);
        rd_reg(1);
        chk("compare_byte1", rdata, 32'hFFFF_ABFF);
        cycle(BASE + 32'd32, 32'h0, 1'b1, 4'hF);
        chk("oow_hit", {31'b0, hit}, 32'd0);
        chk("oow_rdata", rdata, 32'd0);
        rd_reg(1);
        chk("compare_after_oow", rdata, 32'hFFFF_ABFF);

        // Reset with a line held high yields exactly one edge after release
        ext_cur = 5'h1F;
        repeat (4) idle();
        do_reset();
        wr_reg(4, 32'h3F, 4'hF);
        idle(); idle();
        chk("held_high_edge", {26'b0, irq}, 32'h1F);
        wr_reg(3, 32'h1F, 4'h1);
        repeat (4) idle();
        chk("held_high_once", {26'b0, irq}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) ext_cur[$urandom_range(0, 4)] ^= 1'b1;
            ridx = $urandom_range(0, 7);
            ra   = BASE + 32'(ridx * 4);
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            rw = $urandom;
            if (ridx <= 1) rw = 32'($urandom_range(0, 24));
            if (ridx == 2) rw = $urandom & 32'h0000_0303;
            if (n == 400) do_reset();
            cycle(ra, rw, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_timer_intc.md
# mmio_timer_intc

Memory-mapped timer and interrupt controller on the core's data-memory bus. It decodes DMEM accesses in its address window and owns a prescaled 32-bit counter with compare match. It synchronises five external interrupt lines and latches timer and external events into a pending register. It drives the core's six-bit interrupt input as pending AND mask.

## Interface
- BASE_ADDR, 32'h1000_0000: word-aligned base of the 32-byte register window.
- SYNC_STAGES, 2: synchroniser depth for external interrupt lines, ≥2.
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- i_DMEM_addr  in  32  byte address from the core's MEM stage.
- i_DMEM_wdata  in  32  write data.
- i_DMEM_we  in  1  write strobe, one cycle per store.
- i_DMEM_sel  in  4  byte-lane enables; bit n covers wdata[8n+7:8n].
- o_rdata  out  32  read data, valid the cycle after the address is presented.
- o_hit  out  1  registered; 1 when the previous-cycle address fell in the window.
- i_ext_irq  in  5  asynchronous level interrupt sources.
- o_interuption  out  6  to the core's i_interuption; [5] timer, [4:0] external.

## Operation
- Window: hit when i_DMEM_addr[31:5] == BASE_ADDR[31:5]. Register index is addr[4:2]. Misses are ignored, and writes outside the window have no effect.
- Registers:
  - 0x00 COUNT: read/write.
  - 0x04 COMPARE: read/write.
  - 0x08 CTRL: bit0 EN, bit1 AUTO_RELOAD, bits[15:8] PRESCALE; other bits read 0.
  - 0x0C PENDING: bits[5:0], write-1-to-clear.
  - 0x10 MASK: bits[5:0], read/write.
  - 0x14–0x1C: read 0, writes ignored.
- Writes are per byte lane via i_DMEM_sel. For PENDING, only bits in enabled lanes are considered for W1C.
- Prescaler:
  - The 8-bit counter PS increments while EN=1.
  - When PS == PRESCALE, PS←0 and a tick is asserted for one cycle.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds both PS and COUNT.
- Timer:
  - On each tick, COUNT←COUNT+1, wrapping modulo 2^32.
  - If, on a tick, the pre-increment COUNT == COMPARE, PENDING[5] is set.
  - If additionally AUTO_RELOAD=1, COUNT←0 instead of incrementing.
- External lines pass through a SYNC_STAGES-flop synchroniser followed by a rising-edge detect. An edge sets PENDING[i] for one cycle's worth of event. A held-high level does not re-set PENDING after it is cleared.
- o_interuption = PENDING & MASK, combinational from registers.

## Timing
- Reset values:
  - COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, PENDING=0, MASK=0, PS=0.
  - Synchroniser and edge-detect flops are 0.
  - o_rdata=0, o_hit=0, o_interuption=0.
- Read latency is 1 cycle: o_rdata and o_hit are registered from the address of cycle N and valid in cycle N+1. o_rdata is 0 when not hit.
- A write in cycle N is visible to reads presented in cycle N+1 (o_rdata in N+2).
- External edge to PENDING: SYNC_STAGES+1 cycles after i_ext_irq rises. o_interuption follows in the same cycle as PENDING.
- Compare match: PENDING[5] is visible the cycle after the matching tick.
- Simultaneous events:
  - A hardware set and a W1C of the same PENDING bit in the same cycle: the set wins.
  - A COUNT write and a tick in the same cycle: the write wins, and no match is evaluated that cycle.
  - A CTRL write that clears EN takes effect the next cycle; any tick in the write cycle completes.
- Reset asserted mid-operation returns all state to reset values on the next edge, including synchroniser history. A line held high through reset therefore produces one edge after release.

## Structure
- Package mmio_timer_intc_pkg holds:
  - Register offsets (OFF_COUNT, OFF_COMPARE, OFF_CTRL, OFF_PENDING, OFF_MASK).
  - CTRL field positions (CTRL_EN, CTRL_AUTO_RELOAD, CTRL_PS_LSB/MSB).
  - IRQ_TIMER_BIT=5 and COMPARE_RESET=32'hFFFF_FFFF.
- Sub-module irq_edge_sync, instantiated five times: SYNC_STAGES-deep synchroniser plus rising-edge pulse output, with a synchronous active-low reset.
- Top level contains address decode, the byte-lane write helper, prescaler, counter, pending/mask logic and the registered read mux.

## Test plan
- Reset, then read all five registers → COUNT=0, COMPARE=FFFF_FFFF, CTRL=0, PENDING=0, MASK=0; o_interuption=0.
- COMPARE=5, MASK=6'h20, CTRL=EN|AUTO_RELOAD with PRESCALE=0 → PENDING[5] and o_interuption[5] rise 7 cycles after the CTRL write; COUNT reads 0,1,… repeating with period 6.
- PRESCALE=3, EN=1 → COUNT increments once every 4 cycles; writing CTRL=0 freezes COUNT at its current value.
- Pulse i_ext_irq[2] high for 10 cycles with MASK=6'h04 → PENDING[2] set after 3 cycles; W1C with 32'h4, sel=4'b0001 clears it, and it stays clear while the line is still high.
- Assert an edge on line 0 in the same cycle as a W1C of bit 0 → PENDING[0] remains 1.
- Store byte 8'hAB to COMPARE with sel=4'b0010 → COMPARE reads FFFF_ABFF; an access at BASE_ADDR+32 → o_hit=0, o_rdata=0, no register changes.
